// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: turns a stream of ASCII bytes from a UART receiver into hex words.
//
// Hex digits are shifted into an accumulator, most-significant digit first. A word is
// presented when DIGITS digits have been collected, or when CR/LF ends a non-empty word.
// An illegal byte raises a one-cycle word_err. Every following byte is then discarded
// until the next CR/LF.
//
// Build option: define ASCII_HEX_LOWERCASE_EN to accept 'a'-'f' as hex digits. Without
// it, those bytes are illegal.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   rx_data      in   [7:0] ASCII byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  byte accepted this cycle (low only while a word is presented)
//   word_data    out  [W-1:0] parsed value, zero-extended; 0 when word_valid is low
//   word_digits  out  [CW-1:0] digit count of word_data; 0 when word_valid is low
//   word_valid   out  word_data/word_digits valid
//   word_ready   in   downstream accepts the word
//   word_err     out  one-cycle pulse after an illegal byte is accepted
module ascii_hex_parser #(
  parameter int unsigned DIGITS = 4,
  localparam int unsigned W     = 4 * DIGITS,
  localparam int unsigned CW    = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [W-1:0]  word_data,
  output logic [CW-1:0] word_digits,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          word_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold, StFlush} state_e;

  state_e        r_state, w_state_next;
  logic [W-1:0]  r_acc, w_acc_next;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_err, w_err_next;

  logic          w_is_digit;
  logic          w_is_term;
  logic [3:0]    w_nibble;
  logic          w_rx_fire;
  logic          w_word_fire;
  logic [CW-1:0] w_count_inc;
  logic [W-1:0]  w_acc_shift;

  // Byte classification
  always_comb begin
    w_is_digit = 1'b0;
    w_nibble   = 4'd0;
    w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0] + 4'd9;
    end
`ifdef ASCII_HEX_LOWERCASE_EN
    else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0] + 4'd9;
    end
`endif
  end

  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_word_fire = word_valid && word_ready;
  assign w_count_inc = r_count + CW'(1);
  // Shift within W bits so DIGITS=1 needs no special slice
  assign w_acc_shift = (r_acc << 4) | W'(w_nibble);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_err_next   = 1'b0;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_rx_fire) begin
          if (w_is_digit) begin
            w_acc_next   = w_acc_shift;
            w_count_next = w_count_inc;
            w_state_next = (w_count_inc == CW'(DIGITS)) ? StHold : StAccum;
          end else if (w_is_term) begin
            // A terminator with nothing collected is dropped silently
            if (r_count != '0) w_state_next = StHold;
          end else begin
            w_err_next   = 1'b1;
            w_acc_next   = '0;
            w_count_next = '0;
            w_state_next = StFlush;
          end
        end
      end
      StHold: begin
        if (w_word_fire) begin
          w_acc_next   = '0;
          w_count_next = '0;
          w_state_next = StIdle;
        end
      end
      StFlush: begin
        if (w_rx_fire && w_is_term) w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
        w_acc_next   = '0;
        w_count_next = '0;
      end
    endcase
  end

  assign rx_ready    = (r_state != StHold);
  assign word_valid  = (r_state == StHold);
  assign word_data   = word_valid ? r_acc : '0;
  assign word_digits = word_valid ? r_count : '0;
  assign word_err    = r_err;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: runs directed byte sequences and a random byte stream. Each
// run's word/error event list is compared with a byte-level reference model. A DIGITS=1
// instance is also checked.
module tb_ascii_hex_parser;

  localparam logic [31:0] ErrEv = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] word_data;
  logic [2:0]  word_digits;
  logic        word_valid;
  logic        word_ready;
  logic        word_err;

  logic [7:0]  d1_rx_data;
  logic        d1_rx_valid;
  logic        d1_rx_ready;
  logic [3:0]  d1_word_data;
  logic [0:0]  d1_word_digits;
  logic        d1_word_valid;
  logic        d1_word_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          got1_q[$];

  // Reference model state: digits collected so far, their value, discarding after error
  int   m_cnt;
  int   m_val;
  bit   m_flush;

  bit   mon_en     = 1'b0;
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  logic [18:0] prev_word;

  always #5 clk = ~clk;

  ascii_hex_parser #(.DIGITS(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .word_data  (word_data),
    .word_digits(word_digits),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_err   (word_err)
  );

  ascii_hex_parser #(.DIGITS(1)) u_dut_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (d1_rx_data),
    .rx_valid   (d1_rx_valid),
    .rx_ready   (d1_rx_ready),
    .word_data  (d1_word_data),
    .word_digits(d1_word_digits),
    .word_valid (d1_word_valid),
    .word_ready (1'b1),
    .word_err   (d1_word_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 = hex digit (value in d), 1 = terminator, 2 = illegal
  function automatic int classify(input logic [7:0] b, output logic [3:0] d);
    d = 4'd0;
    if (b >= "0" && b <= "9") begin
      d = 4'(b - 8'h30);
      return 0;
    end
    if (b >= "A" && b <= "F") begin
      d = 4'(b - 8'h41 + 8'd10);
      return 0;
    end
`ifdef ASCII_HEX_LOWERCASE_EN
    if (b >= "a" && b <= "f") begin
      d = 4'(b - 8'h61 + 8'd10);
      return 0;
    end
`endif
    if (b == 8'h0D || b == 8'h0A) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_val   = 0;
    m_flush = 1'b0;
  endtask

  task automatic model_emit();
    exp_q.push_back({13'd0, 3'(m_cnt), 16'(m_val)});
    m_cnt = 0;
    m_val = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    logic [3:0] d;
    int c;
    c = classify(b, d);
    if (m_flush) begin
      if (c == 1) m_flush = 1'b0;
    end else if (c == 0) begin
      m_val = m_val * 16 + int'(d);
      m_cnt++;
      if (m_cnt == 4) model_emit();
    end else if (c == 1) begin
      if (m_cnt > 0) model_emit();
    end else begin
      exp_q.push_back(ErrEv);
      m_cnt   = 0;
      m_val   = 0;
      m_flush = 1'b1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  took;
    n        = 0;
    took     = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      took = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (!took) check_eq("send_timeout", 32'd0, 32'd1);
    else model_push(b);
  endtask

  task automatic d1_send(input logic [7:0] b);
    int  n;
    bit  took;
    n           = 0;
    took        = 1'b0;
    d1_rx_data  = b;
    d1_rx_valid = 1'b1;
    do begin
      @(negedge clk);
      took = d1_rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    d1_rx_valid = 1'b0;
    if (!took) check_eq("d1_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq(tag, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Protocol monitor: samples away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("ready_vs_valid", {31'd0, rx_ready}, {31'd0, !word_valid});
      if (!word_valid) begin
        check_eq("idle_data", {16'd0, word_data}, 32'd0);
        check_eq("idle_digits", {29'd0, word_digits}, 32'd0);
      end
      if (prev_stall && rst_n) begin
        check_eq("hold_stable", {12'd0, word_valid, word_digits, word_data},
                 {12'd0, 1'b1, prev_word});
      end
      prev_stall = rst_n && word_valid && !word_ready;
      prev_word  = {word_digits, word_data};
      if (rst_n && word_valid && word_ready) got_q.push_back({13'd0, word_digits, word_data});
      if (word_err) got_q.push_back(ErrEv);
      if (rst_n && d1_word_valid) got1_q.push_back(int'({d1_word_digits, d1_word_data}));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [7:0] b;
    int         r;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    word_ready  = 1'b1;
    d1_rx_data  = 8'h00;
    d1_rx_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state, seen after the first edge with reset released
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check_eq("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check_eq("rst_word_err", {31'd0, word_err}, 32'd0);
    check_eq("rst_word_data", {16'd0, word_data}, 32'd0);
    check_eq("rst_word_digits", {29'd0, word_digits}, 32'd0);
    @(posedge clk);
    #1;

    // Four digits complete a word; it is presented one cycle after the last byte
    send_byte("1"); send_byte("A"); send_byte("F"); send_byte("0");
    @(negedge clk);
    check_eq("lat_valid", {31'd0, word_valid}, 32'd1);
    check_eq("lat_data", {16'd0, word_data}, 32'h1AF0);
    check_eq("lat_digits", {29'd0, word_digits}, 32'd4);
    idle(3);
    compare_events("full_word");

    // Lowercase digit: accepted or illegal depending on the build
    send_byte("1"); send_byte("A"); send_byte("f"); send_byte("0"); send_byte(8'h0D);
    idle(4);
    compare_events("lowercase");

    // Short word ended by CR, then a lone LF produces nothing
    send_byte("7"); send_byte("B"); send_byte(8'h0D);
    idle(3);
    send_byte(8'h0A);
    idle(3);
    compare_events("short_word");

    // Illegal byte: one error pulse, rest of the line discarded
    send_byte("1"); send_byte("2"); send_byte("G"); send_byte("3"); send_byte(8'h0D);
    send_byte("4"); send_byte(8'h0D);
    idle(3);
    compare_events("illegal");

    // Backpressure: word held and input blocked while word_ready is low
    word_ready = 1'b0;
    send_byte("A"); send_byte("B"); send_byte("C"); send_byte("D");
    rx_data  = "E";
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
      check_eq("bp_data", {16'd0, word_data}, 32'hABCD);
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    send_byte("E"); send_byte(8'h0D);
    idle(3);
    compare_events("backpressure");

    // Full word followed by a terminator yields no empty word
    send_byte("9"); send_byte("8"); send_byte("7"); send_byte("6"); send_byte(8'h0D);
    idle(3);
    compare_events("full_then_term");

    // Reset mid-word discards the partial word without an error
    send_byte("1"); send_byte("2");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    send_byte("3"); send_byte(8'h0D);
    idle(3);
    compare_events("reset_mid");

    // DIGITS=1 instance: every digit is a word
    got1_q.delete();
    d1_send("9");
    d1_send("C");
    idle(3);
    check_eq("d1_count", 32'(got1_q.size()), 32'd2);
    if (got1_q.size() > 0) check_eq("d1_word0", 32'(got1_q[0]), 32'h19);
    if (got1_q.size() > 1) check_eq("d1_word1", 32'(got1_q[1]), 32'h1C);

    // Random stream with random gaps and random downstream backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: b = 8'(8'h30 + $urandom_range(0, 9));
        4, 5:       b = 8'(8'h41 + $urandom_range(0, 5));
        6:          b = 8'(8'h61 + $urandom_range(0, 5));
        7:          b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
        default:    b = 8'($urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_byte(b);
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    idle(10);
    compare_events("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
